// File: rtl/axi_pkg.sv
// -----------------------------------------------------------------------------
// axi_pkg
// Shared AXI3 definitions for the memory subsystem: burst and response
// encodings, the fixed beat size used by the burst master, and a helper that
// folds one beat's response into a running burst status.
// -----------------------------------------------------------------------------
package axi_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2
    } axi_burst_e;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } axi_resp_e;

    localparam logic [2:0] AXI_SIZE_4B = 3'b010;

    // Running burst status: keep the worst response seen so far. A protocol
    // error raises the status to at least SLVERR, but a DECERR already seen
    // (or arriving on this beat) is never downgraded.
    function automatic logic [1:0] resp_merge(
        input logic [1:0] acc,
        input logic [1:0] beat,
        input logic       force_err
    );
        logic [1:0] m;
        m = (beat > acc) ? beat : acc;
        if (force_err && (m < SLVERR)) begin
            m = SLVERR;
        end else begin
            m = m;
        end
        return m;
    endfunction

endpackage

// File: rtl/axi_burst_master.sv
// -----------------------------------------------------------------------------
// axi_burst_master
// Single-outstanding AXI3 burst master. Accepts one command at a time on the
// cmd_* handshake and turns it into one AW+W+B write burst or one AR+R read
// burst. Write data and read data are streamed combinationally between the
// wd_*/rd_* streams and the W/R channels. A one-cycle done_o pulse reports the
// transaction ID and final response.
//
// Ports
//   aclk_i, areset_i        clock, async active-low reset
//   cmd_*                   command handshake (write/id/addr/len/burst)
//   wd_*                    write-data stream in (valid/ready/data/strb)
//   rd_*                    read-data stream out (valid/ready/data/last)
//   done_o/_id_o/_resp_o    completion pulse and status
//   aw*/w*/b*/ar*/r*        AXI3 master channels toward axi_slave
// -----------------------------------------------------------------------------
module axi_burst_master
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              aclk_i,
    input  logic              areset_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [ID_W-1:0]   cmd_id_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [3:0]        cmd_len_i,
    input  logic [1:0]        cmd_burst_i,
    input  logic              wd_valid_i,
    output logic              wd_ready_o,
    input  logic [DATA_W-1:0] wd_data_i,
    input  logic [STRB_W-1:0] wd_strb_i,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_last_o,
    output logic              done_o,
    output logic [ID_W-1:0]   done_id_o,
    output logic [1:0]        done_resp_o,
    output logic [ID_W-1:0]   awid_o,
    output logic [ADDR_W-1:0] awaddr_o,
    output logic [3:0]        awlen_o,
    output logic [2:0]        awsize_o,
    output logic [1:0]        awburst_o,
    output logic              awvalid_o,
    input  logic              awready_i,
    output logic [ID_W-1:0]   wid_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [STRB_W-1:0] wstrb_o,
    output logic              wlast_o,
    output logic              wvalid_o,
    input  logic              wready_i,
    input  logic [ID_W-1:0]   bid_i,
    input  logic [1:0]        bresp_i,
    input  logic              bvalid_i,
    output logic              bready_o,
    output logic [ID_W-1:0]   arid_o,
    output logic [ADDR_W-1:0] araddr_o,
    output logic [3:0]        arlen_o,
    output logic [2:0]        arsize_o,
    output logic [1:0]        arburst_o,
    output logic              arvalid_o,
    input  logic              arready_i,
    input  logic [ID_W-1:0]   rid_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        rresp_i,
    input  logic              rlast_i,
    input  logic              rvalid_i,
    output logic              rready_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WADDR = 3'd1,
        S_WDATA = 3'd2,
        S_WRESP = 3'd3,
        S_RADDR = 3'd4,
        S_RDATA = 3'd5,
        S_DONE  = 3'd6
    } state_e;

    state_e            r_state;
    state_e            w_next;
    logic [ID_W-1:0]   r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_len;
    logic [3:0]        r_cnt;
    logic [1:0]        r_burst;
    logic [1:0]        r_resp;

    logic w_last_beat;
    logic w_w_hs;
    logic w_r_hs;
    logic w_r_err;

    assign w_last_beat = (r_cnt == r_len);
    assign w_w_hs      = (r_state == S_WDATA) && wd_valid_i && wready_i;
    assign w_r_hs      = (r_state == S_RDATA) && rvalid_i && rd_ready_i;
    // A read beat is a protocol error if it carries the wrong ID or its
    // rlast disagrees with our own beat count.
    assign w_r_err     = (rid_i != r_id) || (rlast_i != w_last_beat);

    // State register.
    always_ff @(posedge aclk_i or negedge areset_i) begin
        if (!areset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    w_next = cmd_write_i ? S_WADDR : S_RADDR;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_WADDR: begin
                if (awready_i) w_next = S_WDATA;
                else           w_next = S_WADDR;
            end
            S_WDATA: begin
                if (w_w_hs && w_last_beat) w_next = S_WRESP;
                else                       w_next = S_WDATA;
            end
            S_WRESP: begin
                if (bvalid_i) w_next = S_DONE;
                else          w_next = S_WRESP;
            end
            S_RADDR: begin
                if (arready_i) w_next = S_RDATA;
                else           w_next = S_RADDR;
            end
            // The burst ends on our own count, whatever rlast_i says.
            S_RDATA: begin
                if (w_r_hs && w_last_beat) w_next = S_DONE;
                else                       w_next = S_RDATA;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Latched command, beat counter and accumulated response.
    always_ff @(posedge aclk_i or negedge areset_i) begin
        if (!areset_i) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= 4'd0;
            r_burst <= 2'd0;
            r_cnt   <= 4'd0;
            r_resp  <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        r_id    <= cmd_id_i;
                        r_addr  <= cmd_addr_i;
                        r_len   <= cmd_len_i;
                        r_burst <= cmd_burst_i;
                        r_cnt   <= 4'd0;
                        r_resp  <= OKAY;
                    end
                end
                S_WDATA: begin
                    if (w_w_hs && !w_last_beat) r_cnt <= r_cnt + 4'd1;
                end
                S_WRESP: begin
                    if (bvalid_i) r_resp <= (bid_i != r_id) ? SLVERR : bresp_i;
                end
                S_RDATA: begin
                    if (w_r_hs) begin
                        r_resp <= resp_merge(r_resp, rresp_i, w_r_err);
                        if (!w_last_beat) r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // Output decode; every channel is quiet (all zero) outside its own state.
    always_comb begin
        cmd_ready_o = 1'b0;
        wd_ready_o  = 1'b0;
        rd_valid_o  = 1'b0;
        rd_data_o   = '0;
        rd_last_o   = 1'b0;
        done_o      = 1'b0;
        done_id_o   = '0;
        done_resp_o = 2'd0;
        awid_o      = '0;
        awaddr_o    = '0;
        awlen_o     = 4'd0;
        awsize_o    = 3'd0;
        awburst_o   = 2'd0;
        awvalid_o   = 1'b0;
        wid_o       = '0;
        wdata_o     = '0;
        wstrb_o     = '0;
        wlast_o     = 1'b0;
        wvalid_o    = 1'b0;
        bready_o    = 1'b0;
        arid_o      = '0;
        araddr_o    = '0;
        arlen_o     = 4'd0;
        arsize_o    = 3'd0;
        arburst_o   = 2'd0;
        arvalid_o   = 1'b0;
        rready_o    = 1'b0;
        case (r_state)
            S_IDLE: cmd_ready_o = 1'b1;
            S_WADDR: begin
                awvalid_o = 1'b1;
                awid_o    = r_id;
                awaddr_o  = r_addr;
                awlen_o   = r_len;
                awsize_o  = AXI_SIZE_4B;
                awburst_o = r_burst;
            end
            S_WDATA: begin
                wvalid_o   = wd_valid_i;
                wd_ready_o = wready_i;
                wdata_o    = wd_data_i;
                wstrb_o    = wd_strb_i;
                wid_o      = r_id;
                wlast_o    = w_last_beat;
            end
            S_WRESP: bready_o = 1'b1;
            S_RADDR: begin
                arvalid_o = 1'b1;
                arid_o    = r_id;
                araddr_o  = r_addr;
                arlen_o   = r_len;
                arsize_o  = AXI_SIZE_4B;
                arburst_o = r_burst;
            end
            S_RDATA: begin
                rd_valid_o = rvalid_i;
                rready_o   = rd_ready_i;
                rd_data_o  = rdata_i;
                rd_last_o  = w_last_beat;
            end
            S_DONE: begin
                done_o      = 1'b1;
                done_id_o   = r_id;
                done_resp_o = r_resp;
            end
            default: cmd_ready_o = 1'b0;
        endcase
    end

endmodule
